// File: rtl/dvma_pkg.sv
// Shared types and constants for the DVMA bus arbiter.
//   state_t  : arbiter sequencer states
//   REQ_*    : bit positions of each requester in request/grant vectors
//   gnt_t    : one-hot owner {edma, xdma, refresh}
//   RR_*     : round-robin pointer encodings
package dvma_pkg;

  localparam int unsigned NREQ    = 3;
  localparam int unsigned REQ_REF = 0;
  localparam int unsigned REQ_X   = 1;
  localparam int unsigned REQ_E   = 2;

  typedef logic [NREQ-1:0] gnt_t;

  localparam gnt_t GNT_NONE = 3'b000;
  localparam gnt_t GNT_REF  = 3'b001;
  localparam gnt_t GNT_X    = 3'b010;
  localparam gnt_t GNT_E    = 3'b100;

  // Round-robin pointer: which DVMA requester is preferred next.
  localparam logic RR_X = 1'b0;
  localparam logic RR_E = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    BR,
    BGWAIT,
    XFER,
    END,
    HALT,
    BERR
  } state_t;

  // True when the owner is one of the burst-capable DVMA masters.
  function automatic logic is_dvma(input gnt_t g);
    return g[REQ_X] | g[REQ_E];
  endfunction

endpackage

// File: rtl/dvma_rr_pick.sv
// Combinational owner picker: refresh always wins, otherwise the
// round-robin pointer chooses between xdma and edma.
//   req_i : request vector {edma, xdma, refresh}
//   rr_i  : preferred DVMA requester (RR_X / RR_E)
//   gnt_o : one-hot pick, zero when nothing is requested
module dvma_rr_pick
  import dvma_pkg::*;
(
  input  logic [2:0] req_i,
  input  logic       rr_i,
  output logic [2:0] gnt_o
);

  always_comb begin
    gnt_o = GNT_NONE;
    if (req_i[REQ_REF]) begin
      gnt_o = GNT_REF;
    end else if (rr_i == RR_X) begin
      if (req_i[REQ_X])      gnt_o = GNT_X;
      else if (req_i[REQ_E]) gnt_o = GNT_E;
    end else begin
      if (req_i[REQ_E])      gnt_o = GNT_E;
      else if (req_i[REQ_X]) gnt_o = GNT_X;
    end
  end

endmodule

// File: rtl/dvma_bus_arbiter.sv
// 68010 bus-request/grant/acknowledge sequencer shared by refresh,
// Multibus DVMA (xdma) and Ethernet DVMA (edma). Runs bursts of strobed
// transfers per tenure and breaks Multibus deadlock with xhalt/xberr.
// Inputs : CLK, RESET (async, active-high), rreq/xreq/ereq requests,
//          p_bg grant, sas/sds bus strobes, sack acknowledge,
//          sysb Multibus busy, ben board bus enable.
// Outputs: p_br, p_back, p_as, fc1, gnt[2:0] {edma,xdma,refresh},
//          done pulse, xhalt, xberr -- all registered.
module dvma_bus_arbiter
  import dvma_pkg::*;
#(
  parameter int unsigned BG_TIMEOUT = 64,
  parameter int unsigned BURST_MAX  = 4,
  parameter int unsigned TO_W       = 7
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       rreq,
  input  logic       xreq,
  input  logic       ereq,
  input  logic       p_bg,
  input  logic       sas,
  input  logic       sds,
  input  logic       sack,
  input  logic       sysb,
  input  logic       ben,
  output logic       p_br,
  output logic       p_back,
  output logic       p_as,
  output logic       fc1,
  output logic [2:0] gnt,
  output logic       done,
  output logic       xhalt,
  output logic       xberr
);

  localparam int unsigned BC_W = $clog2(BURST_MAX + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(BG_TIMEOUT);
  localparam logic [BC_W-1:0] BC_MAX = BC_W'(BURST_MAX);

  state_t          state_q;
  gnt_t            owner_q;
  logic            rr_q;
  logic [TO_W-1:0] to_q;
  logic [BC_W-1:0] burst_q;

  logic            p_br_q;
  logic            p_back_q;
  logic            p_as_q;
  logic            fc1_q;
  gnt_t            gnt_q;
  logic            done_q;
  logic            xhalt_q;
  logic            xberr_q;

  logic [2:0]      req_vec;
  gnt_t            pick_gnt;
  logic            owner_req;
  logic [TO_W-1:0] to_d;
  logic [BC_W-1:0] burst_d;
  logic            deadlock;
  logic            more;

  assign req_vec = {ereq, xreq, rreq};

  dvma_rr_pick u_pick (
    .req_i (req_vec),
    .rr_i  (rr_q),
    .gnt_o (pick_gnt)
  );

  // Latched owner still requesting.
  assign owner_req = |(owner_q & req_vec);

  // Saturating grant-wait counter; the check uses the value this edge will load.
  assign to_d = (to_q == TO_MAX) ? to_q : to_q + TO_W'(1);

  // Multibus held by another master while the CPU is stuck mid-cycle
  // (or, for refresh, the board bus is disabled): grant will never come.
  assign deadlock = (to_d == TO_MAX) && sysb &&
                    (sds || (owner_q[REQ_REF] && !ben));

  assign burst_d = burst_q + BC_W'(1);

  // Burst continues only for DVMA owners still requesting, below the limit,
  // and with no refresh waiting (refresh preempts at transfer boundaries).
  assign more = is_dvma(owner_q) && owner_req && (burst_q < BC_MAX) && !rreq;

  // Sequencer with registered outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= IDLE;
      owner_q  <= GNT_NONE;
      rr_q     <= RR_X;
      to_q     <= '0;
      burst_q  <= '0;
      p_br_q   <= 1'b0;
      p_back_q <= 1'b0;
      p_as_q   <= 1'b0;
      fc1_q    <= 1'b0;
      gnt_q    <= GNT_NONE;
      done_q   <= 1'b0;
      xhalt_q  <= 1'b0;
      xberr_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (|req_vec) begin
            owner_q <= pick_gnt;
            to_q    <= '0;
            burst_q <= '0;
            p_br_q  <= 1'b1;
            state_q <= BR;
          end
        end

        BR: begin
          to_q <= to_d;
          if (p_bg) begin
            state_q <= BGWAIT;
          end else if (!owner_req) begin
            p_br_q  <= 1'b0;
            owner_q <= GNT_NONE;
            state_q <= IDLE;
          end else if (deadlock) begin
            xhalt_q <= 1'b1;
            state_q <= HALT;
          end
        end

        // One cycle of xhalt alone before bus error joins it.
        HALT: begin
          xberr_q <= 1'b1;
          state_q <= BERR;
        end

        // Hold halt+berr until the CPU releases its address strobe.
        BERR: begin
          if (!sas) begin
            xhalt_q <= 1'b0;
            xberr_q <= 1'b0;
            to_q    <= '0;
            state_q <= BR;
          end
        end

        // Granted; wait for the CPU to finish its current cycle.
        BGWAIT: begin
          if (!sas && !sds) begin
            p_br_q   <= 1'b0;
            p_back_q <= 1'b1;
            p_as_q   <= 1'b1;
            gnt_q    <= owner_q;
            fc1_q    <= is_dvma(owner_q);
            state_q  <= XFER;
          end
        end

        XFER: begin
          if (sack) begin
            p_as_q  <= 1'b0;
            done_q  <= 1'b1;
            burst_q <= burst_d;
            state_q <= END;
          end
        end

        END: begin
          if (more) begin
            p_as_q  <= 1'b1;
            state_q <= XFER;
          end else begin
            p_back_q <= 1'b0;
            gnt_q    <= GNT_NONE;
            fc1_q    <= 1'b0;
            owner_q  <= GNT_NONE;
            if (owner_q[REQ_X])      rr_q <= RR_E;
            else if (owner_q[REQ_E]) rr_q <= RR_X;
            state_q  <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign p_br   = p_br_q;
  assign p_back = p_back_q;
  assign p_as   = p_as_q;
  assign fc1    = fc1_q;
  assign gnt    = gnt_q;
  assign done   = done_q;
  assign xhalt  = xhalt_q;
  assign xberr  = xberr_q;

endmodule

// File: tb/tb_dvma_bus_arbiter.sv
// Self-checking bench for dvma_bus_arbiter: cycle vector table plus
// hand-written deadlock, timeout and async-reset sequences.
module tb_dvma_bus_arbiter;

  localparam int unsigned T  = 8;
  localparam int unsigned BM = 4;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic rreq = 0, xreq = 0, ereq = 0, p_bg = 0, sas = 0, sds = 0;
  logic sack = 0, sysb = 0, ben = 1;
  logic p_br, p_back, p_as, fc1, done, xhalt, xberr;
  logic [2:0] gnt;

  always #5 CLK = ~CLK;

  dvma_bus_arbiter #(.BG_TIMEOUT(T), .BURST_MAX(BM), .TO_W(7)) dut (
    .CLK(CLK), .RESET(RESET), .rreq(rreq), .xreq(xreq), .ereq(ereq),
    .p_bg(p_bg), .sas(sas), .sds(sds), .sack(sack), .sysb(sysb), .ben(ben),
    .p_br(p_br), .p_back(p_back), .p_as(p_as), .fc1(fc1), .gnt(gnt),
    .done(done), .xhalt(xhalt), .xberr(xberr)
  );

  typedef struct {
    logic       rst;
    logic [8:0] in;
    logic [9:0] exp;
    int         seg;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // {rreq,xreq,ereq,p_bg,sas,sds,sack,sysb,ben}
  function automatic logic [8:0] mk_in(logic r, logic x, logic e, logic bg,
                                       logic as_, logic ds, logic ack,
                                       logic sy, logic bn);
    return {r, x, e, bg, as_, ds, ack, sy, bn};
  endfunction

  // {p_br,p_back,p_as,fc1,gnt[2:0],done,xhalt,xberr}
  function automatic logic [9:0] mk_out(logic br, logic back, logic as_, logic f,
                                        logic [2:0] g, logic dn, logic xh, logic xb);
    return {br, back, as_, f, g, dn, xh, xb};
  endfunction

  function automatic logic [9:0] o_xf(logic [2:0] g, logic f);
    return mk_out(0, 1, 1, f, g, 0, 0, 0);
  endfunction

  function automatic logic [9:0] o_en(logic [2:0] g, logic f);
    return mk_out(0, 1, 0, f, g, 1, 0, 0);
  endfunction

  function automatic void add(int seg, logic rst, logic [8:0] in, logic [9:0] exp);
    vec_t v;
    v.rst = rst; v.in = in; v.exp = exp; v.seg = seg;
    tbl.push_back(v);
  endfunction

  task automatic check(string name, int idx, logic [9:0] exp);
    logic [9:0] got;
    got = {p_br, p_back, p_as, fc1, gnt, done, xhalt, xberr};
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %b want %b (br,back,as,fc1,gnt,done,xhalt,xberr)",
               name, idx, got, exp);
    end
  endtask

  // Drive at the falling edge, sample 1 time unit after the rising edge.
  task automatic step(string name, int idx, logic rst, logic [8:0] in, logic [9:0] exp);
    @(negedge CLK);
    RESET = rst;
    {rreq, xreq, ereq, p_bg, sas, sds, sack, sysb, ben} = in;
    @(posedge CLK);
    #1;
    check(name, idx, exp);
  endtask

  localparam logic [9:0] O_0  = 10'b0;
  localparam logic [9:0] O_BR = 10'b1000_000_000;
  localparam logic [9:0] O_HT = 10'b1000_000_010;
  localparam logic [9:0] O_BE = 10'b1000_000_011;

  initial begin
    logic [8:0] iv;
    logic [8:0] iv2;

    // Seg 1: single xdma transfer, grant after 2 cycles, sack after 1.
    add(1, 1, '0, O_0);
    add(1, 0, mk_in(0,1,0,0,0,0,0,0,1), O_BR);
    add(1, 0, mk_in(0,1,0,0,0,0,0,0,1), O_BR);
    add(1, 0, mk_in(0,1,0,1,0,0,0,0,1), O_BR);
    add(1, 0, mk_in(0,1,0,1,0,0,0,0,1), o_xf(3'b010, 1));
    add(1, 0, mk_in(0,1,0,0,0,0,0,0,1), o_xf(3'b010, 1));
    add(1, 0, mk_in(0,1,0,0,0,0,1,0,1), o_en(3'b010, 1));
    add(1, 0, mk_in(0,0,0,0,0,0,0,0,1), O_0);
    add(1, 0, mk_in(0,0,0,0,0,0,0,0,1), O_0);

    // Seg 2: xdma+edma held, immediate grant/ack: 4 x, 4 e, then x again.
    add(2, 1, '0, O_0);
    iv = mk_in(0,1,1,1,0,0,1,0,1);
    add(2, 0, iv, O_BR);
    add(2, 0, iv, O_BR);
    for (int k = 0; k < int'(BM); k++) begin
      add(2, 0, iv, o_xf(3'b010, 1));
      add(2, 0, iv, o_en(3'b010, 1));
    end
    add(2, 0, iv, O_0);
    add(2, 0, iv, O_BR);
    add(2, 0, iv, O_BR);
    for (int k = 0; k < int'(BM); k++) begin
      add(2, 0, iv, o_xf(3'b100, 1));
      add(2, 0, iv, o_en(3'b100, 1));
    end
    add(2, 0, iv, O_0);
    add(2, 0, iv, O_BR);
    add(2, 0, iv, O_BR);
    add(2, 0, iv, o_xf(3'b010, 1));

    // Seg 3: refresh arrives during 2nd xdma transfer, preempts at boundary.
    add(3, 1, '0, O_0);
    iv  = mk_in(0,1,0,1,0,0,1,0,1);
    iv2 = mk_in(1,1,0,1,0,0,1,0,1);
    add(3, 0, iv,  O_BR);
    add(3, 0, iv,  O_BR);
    add(3, 0, iv,  o_xf(3'b010, 1));
    add(3, 0, iv,  o_en(3'b010, 1));
    add(3, 0, iv,  o_xf(3'b010, 1));
    add(3, 0, iv2, o_en(3'b010, 1));
    add(3, 0, iv2, O_0);
    add(3, 0, iv2, O_BR);
    add(3, 0, iv2, O_BR);
    add(3, 0, iv2, o_xf(3'b001, 0));
    add(3, 0, iv2, o_en(3'b001, 0));
    add(3, 0, iv2, O_0);
    add(3, 0, mk_in(0,0,0,1,0,0,1,0,1), O_0);

    // Seg 4: request withdrawn in BR before grant.
    add(4, 1, '0, O_0);
    add(4, 0, mk_in(0,1,0,0,0,0,0,0,1), O_BR);
    add(4, 0, mk_in(0,1,0,0,0,0,0,0,1), O_BR);
    add(4, 0, mk_in(0,0,0,0,0,0,0,0,1), O_0);
    add(4, 0, mk_in(0,0,0,0,0,0,0,0,1), O_0);

    for (int i = 0; i < tbl.size(); i++)
      step($sformatf("seg%0d", tbl[i].seg), i, tbl[i].rst, tbl[i].in, tbl[i].exp);

    // Deadlock on xdma: xhalt at cycle T+1, BERR held by sas, counter restarts.
    step("dl_rst", 0, 1, '0, O_0);
    iv = mk_in(0,1,0,0,1,1,0,1,1);
    for (int k = 1; k <= int'(T); k++) step("dl_wait", k, 0, iv, O_BR);
    step("dl_halt", 0, 0, iv, O_HT);
    for (int k = 0; k < 3; k++) step("dl_berr", k, 0, iv, O_BE);
    iv = mk_in(0,1,0,0,0,1,0,1,1);
    step("dl_clear", 0, 0, iv, O_BR);
    for (int k = 1; k < int'(T); k++) step("dl_rewait", k, 0, iv, O_BR);
    step("dl_rehalt", 0, 0, iv, O_HT);

    // Deadlock on refresh with board bus disabled and no data strobe.
    step("dr_rst", 0, 1, '0, O_0);
    iv = mk_in(1,0,0,0,1,0,0,1,0);
    for (int k = 1; k <= int'(T); k++) step("dr_wait", k, 0, iv, O_BR);
    step("dr_halt", 0, 0, iv, O_HT);
    step("dr_berr", 0, 0, iv, O_BE);

    // Timeout with sysb=0: no halt, p_br held until grant and free bus.
    step("to_rst", 0, 1, '0, O_0);
    iv = mk_in(0,1,0,0,0,1,0,0,1);
    for (int k = 1; k <= 3 * int'(T); k++) step("to_wait", k, 0, iv, O_BR);
    step("to_bg", 0, 0, mk_in(0,1,0,1,0,1,0,0,1), O_BR);
    step("to_busy", 0, 0, mk_in(0,1,0,1,0,1,0,0,1), O_BR);
    step("to_xfer", 0, 0, mk_in(0,1,0,1,0,0,0,0,1), o_xf(3'b010, 1));

    // Asynchronous reset mid-transfer, then a clean fresh tenure.
    @(posedge CLK);
    #2;
    RESET = 1'b1;
    #1;
    check("async_rst", 0, O_0);
    step("ar_hold", 0, 1, mk_in(0,1,0,1,0,0,0,0,1), O_0);
    step("ar_br", 0, 0, mk_in(0,1,0,1,0,0,0,0,1), O_BR);
    step("ar_bgw", 0, 0, mk_in(0,1,0,1,0,0,0,0,1), O_BR);
    step("ar_xfer", 0, 0, mk_in(0,1,0,1,0,0,0,0,1), o_xf(3'b010, 1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
